// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing scheduler.
// Instruction layout is {op[1:0], a[7:0], b[7:0]}, op in the MSBs.
package alu_pkg;

  localparam int INSTR_W = 18;
  localparam int OP_W    = 2;
  localparam int OPD_W   = 8;
  localparam int RES_W   = 16;

  // Field slice positions inside one instruction word
  localparam int OP_MSB = 17;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: request, ALU and response buses of the ALU scheduler.
//   slave  : view of the scheduler (alu_share_ctrl)
//   master : view of the surroundings (requesters, ALU, response sink)
interface alu_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  // Requester side
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*18-1:0] req_instr;
  logic [N_REQ-1:0]    req_ready;
  // ALU side
  logic [1:0]          alu_op;
  logic [7:0]          alu_a;
  logic [7:0]          alu_b;
  logic [15:0]         alu_result;
  logic                alu_neg;
  // Response side
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_result;
  logic                rsp_neg;
  // Status
  logic                busy;

  modport slave (
    input  req_valid, req_instr, alu_result, alu_neg, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_neg, busy
  );

  modport master (
    output req_valid, req_instr, alu_result, alu_neg, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_neg, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating last-grant pointer.
//   clk, reset_n : clock, async active-low reset
//   req[N]       : request vector
//   advance      : grant was consumed; pointer moves to the granted index
//   grant[N]     : one-hot grant (zero when no request)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] r_last;
  logic [PW-1:0] w_gidx;
  logic          w_found;

  // Scan from the entry after the last grant, wrapping modulo N
  always_comb begin
    int unsigned idx;
    grant   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (int'(r_last) + k) % N;
      if (!w_found && req[idx]) begin
        w_found    = 1'b1;
        w_gidx     = PW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Reset to N-1 so requester 0 has first priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_last <= PW'(N - 1);
    else if (advance && w_found)
      r_last <= w_gidx;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin scheduler sharing one external combinational
// ALU among N_REQ requesters.
//   clk     : clock, rising edge
//   reset_n : async active-low reset; discards in-flight work
//   bus     : slave modport of alu_share_ctrl_if
//             req_valid/req_instr/req_ready - per-requester instruction handshake
//             alu_op/alu_a/alu_b            - registered ALU operands
//             alu_result/alu_neg            - ALU output, captured next edge
//             rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_neg - tagged response
//             busy                          - either pipeline stage occupied
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic           clk,
  input logic           reset_n,
  alu_share_ctrl_if.slave bus
);
  logic [N_REQ-1:0]   w_grant;
  logic [N_REQ-1:0]   w_ready;
  logic               w_rsp_adv;
  logic               w_can_acc;
  logic               w_accept;
  logic [ID_W-1:0]    w_gid;
  logic [INSTR_W-1:0] w_instr;

  // Issue stage
  logic               r_iv;
  logic [ID_W-1:0]    r_id;
  logic [OP_W-1:0]    r_op;
  logic [OPD_W-1:0]   r_a;
  logic [OPD_W-1:0]   r_b;
  // Response stage
  logic               r_rv;
  logic [ID_W-1:0]    r_rid;
  logic [RES_W-1:0]   r_res;
  logic               r_neg;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req_valid),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign w_rsp_adv = !r_rv || bus.rsp_ready;
  assign w_can_acc = !r_iv || w_rsp_adv;

  // reset_n gating keeps req_ready low for the whole reset window
  assign w_ready       = (w_can_acc && reset_n) ? w_grant : '0;
  assign bus.req_ready = w_ready;
  assign w_accept      = |(bus.req_valid & w_ready);

  always_comb begin
    w_gid   = '0;
    w_instr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_gid   = ID_W'(i);
        w_instr = bus.req_instr[i*INSTR_W +: INSTR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iv <= 1'b0;
      r_id <= '0;
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_iv <= 1'b1;
      r_id <= w_gid;
      r_op <= w_instr[OP_MSB:OP_LSB];
      r_a  <= w_instr[A_MSB:A_LSB];
      r_b  <= w_instr[B_MSB:B_LSB];
    end else if (r_iv && w_rsp_adv) begin
      r_iv <= 1'b0;
    end
  end

  // When iv is set, rsp_ready implies rsp_adv, so the load branch covers the
  // refill case and the clear branch only fires with an empty issue stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rv  <= 1'b0;
      r_rid <= '0;
      r_res <= '0;
      r_neg <= 1'b0;
    end else if (r_iv && w_rsp_adv) begin
      r_rv  <= 1'b1;
      r_rid <= r_id;
      r_res <= bus.alu_result;
      r_neg <= bus.alu_neg;
    end else if (r_rv && bus.rsp_ready) begin
      r_rv  <= 1'b0;
    end
  end

  assign bus.alu_op     = r_op;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.rsp_valid  = r_rv;
  assign bus.rsp_id     = r_rid;
  assign bus.rsp_result = r_res;
  assign bus.rsp_neg    = r_neg;
  assign bus.busy       = r_iv || r_rv;
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Round-robin scheduler that shares one combinational ALU among `N_REQ` instruction requesters. Each requester offers an 18-bit instruction `{op[1:0], a[7:0], b[7:0]}` on a valid/ready handshake. The block registers the granted instruction onto the ALU inputs, captures the ALU output, and returns it tagged with the requester ID on a valid/ready response port. It sits between the instruction sources (loaders and sequencers) and the `ALU` instance, replacing direct single-owner wiring.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `ID_W`, 2: requester ID width, equal to clog2(`N_REQ`)
- `clk` in 1: single clock; all logic on rising edge
- `reset_n` in 1: asynchronous assert, active-low reset
- `req_valid` in `N_REQ`: per-requester instruction valid
- `req_instr` in `N_REQ`*18: requester i occupies bits [18i+17:18i]
- `req_ready` out `N_REQ`: one-hot or zero; a request is accepted when valid and ready are both high
- `alu_op` out 2: to ALU `OP_CODE`
- `alu_a` out 8, `alu_b` out 8: to ALU `A` and `B`
- `alu_result` in 16, `alu_neg` in 1: from ALU `RESULT` and `NEG`
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake
- `rsp_id` out `ID_W`: ID of the requester that issued the instruction
- `rsp_result` out 16, `rsp_neg` out 1: captured ALU output
- `busy` out 1: high when the issue stage or the response stage holds a valid entry

## Operation
- Two registered stages.
  - Issue register (`iv`, id, op, a, b) drives the ALU directly.
  - Response register (`rv`, id, result, neg).
- Response stage advance: `rsp_adv = !rv | rsp_ready`.
- Issue stage can accept: `can_acc = !iv | rsp_adv`.
- Grant (round-robin):
  - Search starts at `(last_grant + 1) mod N_REQ` and picks the first requester with `req_valid` high.
  - `req_ready[g] = can_acc`; all other `req_ready` bits are 0.
  - `last_grant` updates only on an accepted handshake.
- On acceptance, the issue register loads the granted ID and instruction, and `iv` is set to 1.
- When `iv & rsp_adv`:
  - The response register loads `iv`'s ID together with `alu_result` and `alu_neg`.
  - `rv` is set to 1.
  - If no new acceptance happens in the same cycle, `iv` clears.
- When `rv & rsp_ready & !iv`, `rv` clears.
- Requesters must hold `req_valid` and `req_instr` stable until accepted. The block does not drop or reorder accepted instructions; responses come out in acceptance order.
- Arithmetic is entirely the ALU's. The block passes 16 result bits and NEG unmodified, with no width change.

## Timing
- Reset values:
  - `iv`, `rv`, `rsp_valid`, `busy` = 0.
  - `rsp_id`, `rsp_result`, `rsp_neg`, `alu_op`, `alu_a`, `alu_b` = 0.
  - `last_grant` = `N_REQ`-1, so requester 0 has first priority.
  - `req_ready` = 0 while `reset_n` is low.
- Latency: a handshake at edge k puts the instruction on the ALU ports after edge k. `rsp_valid` rises after edge k+1.
- Throughput is one instruction per cycle while `rsp_ready` stays high.
- `rsp_ready` low with `rv` set:
  - The response register holds.
  - The issue register holds if `iv` is set; `req_ready` is then all 0.
  - If `iv` is clear, one more instruction is accepted into the issue stage.
- `rsp_*` and `alu_*` stay stable while stalled.
- All `req_valid` low: no grant and `last_grant` is unchanged.
- A single active requester is granted every cycle it is valid and can be accepted.
- Pointer wrap: after requester `N_REQ`-1 is granted, the search starts at 0.
- Reset asserted mid-operation: all in-flight instructions are discarded immediately and asynchronously, with no response.
- `req_ready` is combinational from `req_valid`, `last_grant`, `iv`, `rv` and `rsp_ready`. No output depends combinationally on `alu_*` inputs except through registers.

## Structure
- Shared package `alu_pkg`:
  - `INSTR_W`=18, `OP_W`=2, `OPD_W`=8, `RES_W`=16.
  - Opcode constants: `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_MUL`=2'b10, `OP_AND`=2'b11.
  - Instruction field slice positions.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N]`, `advance`.
  - Output `grant[N]` one-hot.
  - Holds the rotating `last_grant` pointer.
- The top holds both pipeline registers and the handshake logic. The ALU is instantiated outside this block.

## Test plan
- Reset, then requester 0 sends {`OP_ADD`, 8'd5, 8'd7}, `rsp_ready`=1 → `alu_*` = (0, 5, 7) one cycle later; `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12, `rsp_neg`=0 the cycle after.
- Requesters 0-3 all valid and continuously ready → grants 0,1,2,3,0,... one per cycle; four responses on consecutive cycles with IDs 0,1,2,3.
- Requester 2 sends {`OP_SUB`, 3, 10} → `rsp_result`=7, `rsp_neg`=1, `rsp_id`=2.
- `rsp_ready` held low for 5 cycles with requester 1 streaming {`OP_MUL`, 255, 255} → exactly two accepts, `req_ready`=0 afterwards, `rsp_result`=65025 stable; on release, responses drain in order with no loss.
- Requester 3 alone valid for 3 cycles → accepted every cycle; then requesters 0 and 3 valid → 0 granted first (search wraps after 3).
- `reset_n` pulsed low while both stages are full → `rsp_valid` and `busy` drop immediately; no response appears after release until a new request arrives.
